// File: rtl/boot_rom_pkg.sv
// boot_rom_pkg: shared types and constants for the boot ROM arbiter.
//   req_port_e    - which requester (instruction fetch or data) owns an access
//   rom_rsp_t     - registered response-stage record (valid, owning port, error)
//   ROM_ERR_RDATA - read data returned with an error response
package boot_rom_pkg;
    typedef enum logic {REQ_INSTR, REQ_DATA} req_port_e;
    typedef struct packed {logic vld; req_port_e port; logic err;} rom_rsp_t;
    localparam logic [63:0] ROM_ERR_RDATA = '0;
endpackage

// File: rtl/boot_rom_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin arbiter with combinational grant.
//   CLK    in  clock
//   RST    in  synchronous active-high reset; forces both grants low
//   req_i  in  [1:0] requests, bit 0 = instruction port, bit 1 = data port
//   gnt_o  out [1:0] one-hot grant (at most one bit set)
module rr_arbiter_2 import boot_rom_pkg::*; (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    req_port_e last_q;
    // On a tie the port that did not win last time is served.
    assign gnt_o[0] = !RST && req_i[0] && (!req_i[1] || last_q == REQ_DATA);
    assign gnt_o[1] = !RST && req_i[1] && (!req_i[0] || last_q == REQ_INSTR);
    // Reset to DATA so the first tie after reset goes to instruction fetch.
    always_ff @(posedge CLK)
        last_q <= RST ? REQ_DATA : gnt_o[0] ? REQ_INSTR : gnt_o[1] ? REQ_DATA : last_q;
endmodule

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: shares one single-port synchronous boot ROM between fetch and data ports.
//   CLK, RST                          clock, synchronous active-high reset
//   instr_req_i/addr_i                fetch request and byte address
//   instr_gnt_o/rvalid_o/rdata_o/err_o fetch grant and one-cycle-later response
//   data_req_i/we_i/addr_i            data request, write enable (always an error), byte address
//   data_gnt_o/rvalid_o/rdata_o/err_o data grant and one-cycle-later response
//   rom_cen_o, rom_a_o, rom_q_i       ROM chip enable (active-low), word address, read data
module boot_rom_arbiter import boot_rom_pkg::*; #(
    parameter int          ROM_ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h1A000000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      instr_req_i,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]     instr_rdata_o,
    output logic                      instr_err_o,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [31:0]               data_addr_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_err_o,
    output logic                      rom_cen_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_a_o,
    input  logic [DATA_WIDTH-1:0]     rom_q_i
);
    localparam int RAW = ROM_ADDR_WIDTH;
    logic [1:0]  gnt;
    logic        any_gnt;
    logic        ok;
    logic [31:0] addr;
    logic        i_vld;
    logic        d_vld;
    rom_rsp_t    rsp_d;
    rom_rsp_t    rsp_q;
    rr_arbiter_2 u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .req_i ({data_req_i, instr_req_i}),
        .gnt_o (gnt)
    );
    assign instr_gnt_o = gnt[0];
    assign data_gnt_o  = gnt[1];
    always_comb begin
        any_gnt = |gnt;
        addr    = gnt[1] ? data_addr_i : instr_addr_i;
        ok      = addr[31:RAW+2] == BASE_ADDR[31:RAW+2] && addr[1:0] == 2'b00 && !(gnt[1] && data_we_i);
        rsp_d   = '{vld: any_gnt, port: gnt[1] ? REQ_DATA : REQ_INSTR, err: !ok};
    end
    // Rejected accesses are still granted but never touch the ROM.
    assign rom_cen_o = !(any_gnt && ok);
    assign rom_a_o   = any_gnt ? addr[RAW+1:2] : '0;
    always_ff @(posedge CLK)
        rsp_q <= RST ? '0 : rsp_d;
    always_comb begin
        i_vld          = rsp_q.vld && rsp_q.port == REQ_INSTR;
        d_vld          = rsp_q.vld && rsp_q.port == REQ_DATA;
        instr_rvalid_o = i_vld;
        data_rvalid_o  = d_vld;
        instr_err_o    = i_vld && rsp_q.err;
        data_err_o     = d_vld && rsp_q.err;
        instr_rdata_o  = !i_vld ? '0 : rsp_q.err ? DATA_WIDTH'(ROM_ERR_RDATA) : rom_q_i;
        data_rdata_o   = !d_vld ? '0 : rsp_q.err ? DATA_WIDTH'(ROM_ERR_RDATA) : rom_q_i;
    end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb_boot_rom_arbiter: directed stimulus with a response scoreboard for boot_rom_arbiter.
module tb_boot_rom_arbiter;
    typedef struct {logic port; logic err; logic [31:0] data;} exp_t;
    logic        clk = 0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [31:0] data_addr, data_rdata;
    logic        rom_cen;
    logic [9:0]  rom_a;
    logic [31:0] rom_q;
    logic [31:0] mem [1024];
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    always #5 clk = ~clk;
    boot_rom_arbiter dut (
        .CLK(clk), .RST(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .rom_cen_o(rom_cen), .rom_a_o(rom_a), .rom_q_i(rom_q)
    );
    // Synchronous ROM; rom_q keeps stale data when not enabled so error masking is visible.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 | i;
        mem[32]   = 32'h1C008537;
        mem[33]   = 32'h08050513;
        mem[1023] = 32'hDEADBEEF;
        rom_q     = 32'hBAD0BAD0;
    end
    always @(posedge clk) if (!rom_cen) rom_q <= mem[rom_a];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask
    // eg: expected grant 0=none 1=instr 2=data; ea<0 skips the address check.
    task automatic cyc(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input int eg, input logic ecen, input int ea,
                       input logic [31:0] erd, input string nm);
        exp_t e;
        rst = r; instr_req = ir; instr_addr = ia;
        data_req = dr; data_we = dw; data_addr = da;
        @(negedge clk);
        chk({nm, " instr_gnt"}, 32'(instr_gnt), 32'(eg == 1));
        chk({nm, " data_gnt"}, 32'(data_gnt), 32'(eg == 2));
        chk({nm, " rom_cen"}, 32'(rom_cen), 32'(ecen));
        if (ea >= 0) chk({nm, " rom_a"}, 32'(rom_a), 32'(ea));
        if (eg != 0) begin
            e.port = (eg == 2);
            e.err  = ecen;
            e.data = ecen ? 32'h0 : erd;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (instr_rvalid && data_rvalid) chk("both rvalid", 32'd1, 32'd0);
        else if (instr_rvalid || data_rvalid) begin
            if (q.size() == 0) chk("unexpected rvalid", 32'(data_rvalid), 32'hFFFFFFFF);
            else begin
                e = q.pop_front();
                chk("rsp port", 32'(data_rvalid), 32'(e.port));
                chk("rsp err", 32'(data_rvalid ? data_err : instr_err), 32'(e.err));
                chk("rsp rdata", data_rvalid ? data_rdata : instr_rdata, e.data);
            end
        end
        if (!instr_rvalid) chk("idle instr rdata/err", {instr_rdata[30:0], instr_err}, 32'h0);
        if (!data_rvalid) chk("idle data rdata/err", {data_rdata[30:0], data_err}, 32'h0);
    end
    initial begin
        cyc(1, 1, 32'h1A000080, 1, 0, 32'h1A000084, 0, 1, 0, 0, "rst0");
        cyc(1, 1, 32'h1A000080, 1, 1, 32'h1A000084, 0, 1, 0, 0, "rst1");
        cyc(0, 1, 32'h1A000080, 1, 0, 32'h1A000084, 1, 0, 32, 32'h1C008537, "t2a");
        cyc(0, 1, 32'h1A000080, 1, 0, 32'h1A000084, 2, 0, 33, 32'h08050513, "t2b");
        cyc(0, 1, 32'h1A000080, 1, 0, 32'h1A000084, 1, 0, 32, 32'h1C008537, "t2c");
        cyc(0, 1, 32'h1A000080, 1, 0, 32'h1A000084, 2, 0, 33, 32'h08050513, "t2d");
        cyc(0, 1, 32'h1A000080, 0, 0, 32'h0, 1, 0, 32, 32'h1C008537, "t1");
        cyc(0, 0, 32'h0, 1, 1, 32'h1A000084, 2, 1, -1, 0, "t3we");
        cyc(0, 0, 32'h0, 1, 0, 32'h1A000080, 2, 0, 32, 32'h1C008537, "drd");
        cyc(0, 1, 32'h1A001000, 0, 0, 32'h0, 1, 1, -1, 0, "t4over");
        cyc(0, 1, 32'h1A000002, 0, 0, 32'h0, 1, 1, -1, 0, "t4mis");
        cyc(0, 1, 32'h19FFFFFC, 0, 0, 32'h0, 1, 1, -1, 0, "t4under");
        cyc(0, 1, 32'h1A000FFC, 0, 0, 32'h0, 1, 0, 1023, 32'hDEADBEEF, "t4last");
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, "idle");
        cyc(0, 1, 32'h1A000080, 0, 0, 32'h0, 1, 0, 32, 32'h1C008537, "t5a");
        cyc(0, 1, 32'h1A000084, 0, 0, 32'h0, 1, 0, 33, 32'h08050513, "t5b");
        cyc(1, 1, 32'h1A000080, 1, 0, 32'h1A000084, 0, 1, 0, 0, "t6rst");
        cyc(0, 1, 32'h1A000080, 1, 0, 32'h1A000084, 1, 0, 32, 32'h1C008537, "t6tie");
        cyc(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, "drain");
        chk("pending responses", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
